// File: rtl/cd_mult_seq_if.sv
// cd_mult_seq_if
// Operand/result handshake bundle for the iterative carry-disregard
// multiplier.
//   in_valid/in_ready  : operand handshake (master -> slave)
//   in_a, in_b         : multiplicand (WA bits) and multiplier (WB bits), unsigned
//   in_k               : carry-disregard column count K (KW bits)
//   out_valid/out_ready: result handshake (slave -> master)
//   out_r              : approximate product (WA+WB bits)
//   busy               : slave is running or holding a result
// master = producer/consumer side, slave = the multiplier.
interface cd_mult_seq_if #(
  parameter int WA = 8,
  parameter int WB = 4,
  parameter int KW = $clog2(WA + WB + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [WA-1:0]     in_a;
  logic [WB-1:0]     in_b;
  logic [KW-1:0]     in_k;
  logic              out_valid;
  logic              out_ready;
  logic [WA+WB-1:0]  out_r;
  logic              busy;

  modport master (
    output in_valid, in_a, in_b, in_k, out_ready,
    input  in_ready, out_valid, out_r, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_k, out_ready,
    output in_ready, out_valid, out_r, busy
  );
endinterface

// File: rtl/cd_mult_seq.sv
// cd_mult_seq
// Iterative carry-disregard approximate multiplier. One partial-product
// row (one bit of B) is accumulated per cycle. Columns below K combine by
// XOR (carries dropped); columns K and above add with full carry, with
// zero carry-in at column K. K=0 gives the exact product, K>=N pure XOR.
// Ports:
//   clk   : clock, all state changes on rising edge
//   rst_n : synchronous active-low reset
//   bus   : cd_mult_seq_if.slave (operand/result handshake, busy)
// Parameters: WA, WB operand widths; KW width of K; EARLY_EXIT stops the
// row loop once no set B bits remain.
module cd_mult_seq #(
  parameter int WA         = 8,
  parameter int WB         = 4,
  parameter int KW         = $clog2(WA + WB + 1),
  parameter int EARLY_EXIT = 0
) (
  input logic          clk,
  input logic          rst_n,
  cd_mult_seq_if.slave bus
);
  localparam int N  = WA + WB;
  localparam int IW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [N:0] ONE_WIDE = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [WA-1:0] a_reg, a_next;
  logic [WB-1:0] b_reg, b_next;
  logic [KW-1:0] k_reg, k_next;
  logic [N-1:0]  acc, acc_next;
  logic [IW-1:0] idx, idx_next;
  logic          out_valid, out_valid_next;
  logic [N-1:0]  out_r, out_r_next;

  logic [KW-1:0] k_eff;
  logic [N-1:0]  pp;
  logic [N-1:0]  low_mask;
  logic [N-1:0]  hi_sum;
  logic [N-1:0]  row_sum;
  logic [IW:0]   idx_inc;
  logic          last_row;

  // K larger than the product width behaves exactly like K=N.
  assign k_eff = (bus.in_k > KW'(N)) ? KW'(N) : bus.in_k;

  // Row datapath: low K columns XOR, upper columns are one aligned add
  // whose carry-in is zero because the low part never feeds it.
  always_comb begin
    pp       = b_reg[idx] ? ({{WB{1'b0}}, a_reg} << idx) : '0;
    low_mask = N'((ONE_WIDE << k_reg) - ONE_WIDE);
    hi_sum   = (acc >> k_reg) + (pp >> k_reg);
    row_sum  = ((acc ^ pp) & low_mask) | (hi_sum << k_reg);
  end

  // idx_inc is one bit wider so idx=WB-1 does not wrap to zero before
  // the early-exit shift.
  assign idx_inc  = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
  assign last_row = (idx == IW'(WB - 1)) ||
                    ((EARLY_EXIT != 0) && ((b_reg >> idx_inc) == '0));

  always_comb begin
    state_next     = state;
    a_next         = a_reg;
    b_next         = b_reg;
    k_next         = k_reg;
    acc_next       = acc;
    idx_next       = idx;
    out_valid_next = out_valid;
    out_r_next     = out_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.in_a;
          b_next     = bus.in_b;
          k_next     = k_eff;
          acc_next   = '0;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = row_sum;
        idx_next = idx + IW'(1);
        if (last_row) begin
          out_valid_next = 1'b1;
          out_r_next     = row_sum;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      k_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
    end else begin
      state     <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      k_reg     <= k_next;
      acc       <= acc_next;
      idx       <= idx_next;
      out_valid <= out_valid_next;
      out_r     <= out_r_next;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.out_valid = out_valid;
  assign bus.out_r     = out_r;
endmodule

// File: tb/tb_cd_mult_seq.sv
// tb_cd_mult_seq
// Scoreboard bench for cd_mult_seq (WA=8, WB=4). Two instances: dut0 with
// EARLY_EXIT=0 and dut1 with EARLY_EXIT=1. Stimulus pushes expected result
// and latency; a negedge monitor checks latency, hold stability and the
// result at each output handshake.
module tb_cd_mult_seq;
  localparam int WA = 8;
  localparam int WB = 4;
  localparam int N  = WA + WB;
  localparam int KW = $clog2(N + 1);

  typedef struct {
    logic [N-1:0] r;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   hold_len0;
  bit   rand_stall;
  bit   prev_valid0;
  bit   prev_valid1;
  int   held0;
  int   held1;
  exp_t sb0[$];
  exp_t sb1[$];

  cd_mult_seq_if #(.WA(WA), .WB(WB), .KW(KW)) bus0 ();
  cd_mult_seq_if #(.WA(WA), .WB(WB), .KW(KW)) bus1 ();

  cd_mult_seq #(.WA(WA), .WB(WB), .KW(KW), .EARLY_EXIT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  cd_mult_seq #(.WA(WA), .WB(WB), .KW(KW), .EARLY_EXIT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Bit-serial reference: ripple each column, dropping carries below K.
  function automatic logic [N-1:0] refModel(input logic [WA-1:0] a,
                                            input logic [WB-1:0] b,
                                            input logic [KW-1:0] k);
    int           ke;
    logic [N-1:0] acc;
    logic [N-1:0] pp;
    logic         c;
    logic         s;
    ke  = (int'(k) > N) ? N : int'(k);
    acc = '0;
    for (int i = 0; i < WB; i++) begin
      pp = b[i] ? (N'(a) << i) : '0;
      c  = 1'b0;
      for (int col = 0; col < N; col++) begin
        if (col < ke) begin
          acc[col] = acc[col] ^ pp[col];
        end else begin
          s        = acc[col] ^ pp[col] ^ c;
          c        = (acc[col] & pp[col]) | (acc[col] & c) | (pp[col] & c);
          acc[col] = s;
        end
      end
    end
    return acc;
  endfunction

  function automatic int latModel(input bit ee, input logic [WB-1:0] b);
    int h;
    if (!ee) return WB;
    h = -1;
    for (int i = 0; i < WB; i++) if (b[i]) h = i;
    return (h < 0) ? 1 : h + 1;
  endfunction

  function automatic logic inReady(input bit d);
    return d ? bus1.in_ready : bus0.in_ready;
  endfunction

  task automatic driveIn(input bit d, input logic v, input logic [WA-1:0] a,
                         input logic [WB-1:0] b, input logic [KW-1:0] k);
    if (d) begin
      bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b; bus1.in_k = k;
    end else begin
      bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b; bus0.in_k = k;
    end
  endtask

  // Issue one operation; the inputs are scrambled right after accept so a
  // design that fails to latch them produces a wrong result.
  task automatic applyStimulus(input bit d, input logic [WA-1:0] a,
                               input logic [WB-1:0] b, input logic [KW-1:0] k,
                               input logic [N-1:0] exp_r, input int lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!inReady(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!inReady(d)) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    driveIn(d, 1'b1, a, b, k);
    e.r       = exp_r;
    e.lat     = lat;
    e.acc_cyc = cyc + 1;
    if (d) sb1.push_back(e);
    else   sb0.push_back(e);
    @(negedge clk);
    driveIn(d, 1'b0, ~a, ~b, ~k);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0 || !bus0.in_ready ||
            !bus1.in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic monitorStep(input bit d, input logic v, input logic rdy,
                             input logic irdy, input logic [N-1:0] r);
    exp_t e;
    bit   have;
    bit   pv;
    string tag;
    tag  = d ? "dut1" : "dut0";
    have = d ? (sb1.size() > 0) : (sb0.size() > 0);
    pv   = d ? prev_valid1 : prev_valid0;
    if (v && !have) begin
      checkOutput({tag, "_unexpected_result"}, 32'(r), 32'hFFFF_FFFF);
    end else if (v) begin
      e = d ? sb1[0] : sb0[0];
      if (!pv) checkOutput({tag, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
      checkOutput({tag, "_in_ready_while_done"}, 32'(irdy), 32'd0);
      if (rdy) begin
        checkOutput({tag, "_result"}, 32'(r), 32'(e.r));
        if (d) void'(sb1.pop_front());
        else   void'(sb0.pop_front());
      end else begin
        checkOutput({tag, "_result_held"}, 32'(r), 32'(e.r));
      end
    end
    if (d) prev_valid1 = v;
    else   prev_valid0 = v;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitorStep(1'b0, bus0.out_valid, bus0.out_ready, bus0.in_ready, bus0.out_r);
      monitorStep(1'b1, bus1.out_valid, bus1.out_ready, bus1.in_ready, bus1.out_r);
    end
  end

  // Consumer side: optional fixed hold on dut0, optional random stalls.
  always @(posedge clk) begin
    #2;
    if (bus0.out_valid && held0 < hold_len0) begin
      bus0.out_ready = 1'b0;
      held0++;
    end else begin
      bus0.out_ready = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!bus0.out_valid) held0 = 0;
    end
    if (!bus1.out_valid) held1 = 0;
    bus1.out_ready = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  initial begin
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    logic [KW-1:0] rk;
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    hold_len0   = 0;
    rand_stall  = 1'b0;
    held0       = 0;
    held1       = 0;
    rst_n       = 1'b0;
    driveIn(1'b0, 1'b0, '0, '0, '0);
    driveIn(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);

    checkOutput("reset_in_ready", 32'(bus0.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("reset_out_r", 32'(bus0.out_r), 32'd0);
    checkOutput("reset_busy", 32'(bus0.busy), 32'd0);
    checkOutput("reset_ee_in_ready", 32'(bus1.in_ready), 32'd1);
    checkOutput("reset_ee_busy", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed vectors, EARLY_EXIT=0");
    applyStimulus(1'b0, 8'd255, 4'd15, 4'd0,  12'd3825, 4);
    applyStimulus(1'b0, 8'd255, 4'd15, 4'd7,  12'd3333, 4);
    applyStimulus(1'b0, 8'd255, 4'd15, 4'd12, 12'd1285, 4);
    applyStimulus(1'b0, 8'd3,   4'd3,  4'd12, 12'd5,    4);
    applyStimulus(1'b0, 8'd3,   4'd3,  4'd15, 12'd5,    4);
    waitDrain();

    $display("[TB] backpressure hold");
    hold_len0 = 6;
    applyStimulus(1'b0, 8'd10, 4'd5, 4'd0, 12'd50, 4);
    waitDrain();
    hold_len0 = 0;

    $display("[TB] directed vectors, EARLY_EXIT=1");
    applyStimulus(1'b1, 8'd200, 4'd1, 4'd0, 12'd200,  1);
    applyStimulus(1'b1, 8'd200, 4'd0, 4'd0, 12'd0,    1);
    applyStimulus(1'b1, 8'd200, 4'd8, 4'd0, 12'd1600, 4);
    waitDrain();

    $display("[TB] reset during RUN");
    @(negedge clk);
    driveIn(1'b0, 1'b1, 8'd10, 4'd15, 4'd0);
    @(posedge clk);
    @(negedge clk);
    driveIn(1'b0, 1'b0, 8'd0, 4'd0, 4'd0);
    checkOutput("run_busy", 32'(bus0.busy), 32'd1);
    checkOutput("run_in_ready", 32'(bus0.in_ready), 32'd0);
    checkOutput("idle_out_r_retained", 32'(bus0.out_r), 32'd50);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_in_ready", 32'(bus0.in_ready), 32'd1);
    checkOutput("midrun_reset_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("midrun_reset_out_r", 32'(bus0.out_r), 32'd0);
    checkOutput("midrun_reset_busy", 32'(bus0.busy), 32'd0);
    checkOutput("midrun_reset_ee_out_r", 32'(bus1.out_r), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd7, 4'd9, 4'd0, 12'd63, 4);
    waitDrain();

    $display("[TB] random sweep with stalls");
    rand_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = WA'($urandom);
      rb = WB'($urandom);
      rk = KW'($urandom_range(0, N + 3));
      applyStimulus(1'b0, ra, rb, rk, refModel(ra, rb, rk), latModel(1'b0, rb));
      ra = WA'($urandom);
      rb = WB'($urandom);
      rk = KW'($urandom_range(0, N + 3));
      applyStimulus(1'b1, ra, rb, rk, refModel(ra, rb, rk), latModel(1'b1, rb));
    end
    waitDrain();
    rand_stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
